// File: rtl/pipes_scroller.sv
// Pipe scroller: moves two pipes left on each Tick, wraps them to the right,
// and runs the IDLE/RUN/DEAD game state machine and the pipes-passed score.
module pipes_scroller #(
    parameter logic [15:0] SCREEN_W     = 16'd640,
    parameter logic [15:0] PIPE_SPACING = 16'd320,
    parameter logic [15:0] STEP         = 16'd2,
    parameter logic [15:0] BIRD_X       = 16'd200
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Tick,
    input  logic        Button,
    input  logic        Collision,
    output logic [15:0] PipesPosition1,
    output logic [15:0] PipesPosition2,
    output logic        Wrap1,
    output logic        Wrap2,
    output logic [15:0] Score,
    output logic        Running
);

    localparam logic [15:0] POS2_INIT = SCREEN_W + PIPE_SPACING;
    localparam logic [15:0] WRAP      = (PIPE_SPACING << 1) - STEP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        btn_q;
    logic [15:0] pos1_q, pos1_d;
    logic [15:0] pos2_q, pos2_d;
    logic [15:0] score_q, score_d;
    logic        wrap1_q, wrap1_d;
    logic        wrap2_q, wrap2_d;
    logic        running_q, running_d;

    logic        fall;
    logic [15:0] nxt1, nxt2;
    logic        cross1, cross2;
    logic [16:0] score_sum;

    // Clamp to 0 so every pipe sits at exactly 0 for one tick before wrapping.
    function automatic logic [15:0] pipe_next(input logic [15:0] p);
        if (p == 16'd0)
            return WRAP;
        else if (p <= STEP)
            return 16'd0;
        else
            return p - STEP;
    endfunction

    always_comb begin
        fall      = ~Button & btn_q;
        nxt1      = pipe_next(pos1_q);
        nxt2      = pipe_next(pos2_q);
        cross1    = (pos1_q >= BIRD_X) && (nxt1 < BIRD_X);
        cross2    = (pos2_q >= BIRD_X) && (nxt2 < BIRD_X);
        score_sum = {1'b0, score_q} + {16'd0, cross1} + {16'd0, cross2};

        state_d = state_q;
        pos1_d  = pos1_q;
        pos2_d  = pos2_q;
        score_d = score_q;
        wrap1_d = 1'b0;
        wrap2_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    score_d = 16'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (Collision) begin
                    state_d = DEAD;
                end else if (Tick) begin
                    pos1_d  = nxt1;
                    pos2_d  = nxt2;
                    wrap1_d = (pos1_q == 16'd0);
                    wrap2_d = (pos2_q == 16'd0);
                    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                end
            end
            DEAD: begin
                if (fall) begin
                    state_d = IDLE;
                    pos1_d  = SCREEN_W;
                    pos2_d  = POS2_INIT;
                end
            end
            default: state_d = IDLE;
        endcase

        running_d = (state_d == RUN);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            btn_q     <= 1'b1;
            pos1_q    <= SCREEN_W;
            pos2_q    <= POS2_INIT;
            score_q   <= 16'd0;
            wrap1_q   <= 1'b0;
            wrap2_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            btn_q     <= Button;
            pos1_q    <= pos1_d;
            pos2_q    <= pos2_d;
            score_q   <= score_d;
            wrap1_q   <= wrap1_d;
            wrap2_q   <= wrap2_d;
            running_q <= running_d;
        end
    end

    assign PipesPosition1 = pos1_q;
    assign PipesPosition2 = pos2_q;
    assign Wrap1          = wrap1_q;
    assign Wrap2          = wrap2_q;
    assign Score          = score_q;
    assign Running        = running_q;

endmodule

// File: tb/tb_pipes_scroller.sv
// Bench for pipes_scroller: two builds (STEP=2 default, STEP=3 offset start)
// checked every cycle against a game-rule model, plus literal spot checks.
module tb_pipes_scroller;

    logic clk = 1'b0;
    logic rst_n, tick, btn, col;
    logic chk_en = 1'b0;

    logic [1:0][15:0] p1, p2, sc;
    logic [1:0]       w1, w2, run;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipes_scroller u0 (
        .Clk(clk), .Reset(rst_n), .Tick(tick), .Button(btn),
        .Collision(col),
        .PipesPosition1(p1[0]), .PipesPosition2(p2[0]),
        .Wrap1(w1[0]), .Wrap2(w2[0]), .Score(sc[0]), .Running(run[0])
    );

    pipes_scroller #(
        .SCREEN_W(16'd644), .PIPE_SPACING(16'd320),
        .STEP(16'd3), .BIRD_X(16'd200)
    ) u1 (
        .Clk(clk), .Reset(rst_n), .Tick(tick), .Button(btn),
        .Collision(col),
        .PipesPosition1(p1[1]), .PipesPosition2(p2[1]),
        .Wrap1(w1[1]), .Wrap2(w2[1]), .Score(sc[1]), .Running(run[1])
    );

    // Game-rule model: st 0=IDLE 1=RUN 2=DEAD
    typedef struct {
        int st; int p1; int p2; int sc; bit w1; bit w2; bit prev;
    } mdl_t;

    mdl_t m[2];
    int   sw[2]  = '{640, 644};
    int   stp[2] = '{2, 3};

    function automatic int mv(int p, int s);
        if (p == 0) return 640 - s;
        if (p <= s) return 0;
        return p - s;
    endfunction

    function automatic mdl_t mstep(mdl_t o, int i, bit r, bit tk,
                                   bit bt, bit co);
        mdl_t n = o;
        int   cnt;
        bit   fall = !bt && o.prev;
        n.w1 = 0; n.w2 = 0; n.prev = bt;
        if (!r) begin
            n.st = 0; n.p1 = sw[i]; n.p2 = sw[i] + 320;
            n.sc = 0; n.prev = 1;
            return n;
        end
        if (o.st == 0 && fall) begin
            n.sc = 0; n.st = 1;
        end else if (o.st == 1 && co) begin
            n.st = 2;
        end else if (o.st == 1 && tk) begin
            n.p1 = mv(o.p1, stp[i]);
            n.p2 = mv(o.p2, stp[i]);
            n.w1 = (o.p1 == 0);
            n.w2 = (o.p2 == 0);
            cnt = ((o.p1 >= 200 && n.p1 < 200) ? 1 : 0)
                + ((o.p2 >= 200 && n.p2 < 200) ? 1 : 0);
            n.sc = (o.sc + cnt > 65535) ? 65535 : o.sc + cnt;
        end else if (o.st == 2 && fall) begin
            n.st = 0; n.p1 = sw[i]; n.p2 = sw[i] + 320;
        end
        return n;
    endfunction

    always @(posedge clk)
        for (int i = 0; i < 2; i++)
            m[i] <= mstep(m[i], i, rst_n, tick, btn, col);

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d.pos1", i), 32'(p1[i]), m[i].p1);
                check($sformatf("u%0d.pos2", i), 32'(p2[i]), m[i].p2);
                check($sformatf("u%0d.wrap1", i), 32'(w1[i]), 32'(m[i].w1));
                check($sformatf("u%0d.wrap2", i), 32'(w2[i]), 32'(m[i].w2));
                check($sformatf("u%0d.score", i), 32'(sc[i]), m[i].sc);
                check($sformatf("u%0d.running", i), 32'(run[i]),
                      (m[i].st == 1) ? 32'd1 : 32'd0);
            end
        end
    end

    task automatic do_tick(int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    task automatic press();
        @(negedge clk) btn = 1'b0;
        @(negedge clk) btn = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; btn = 1'b1; col = 1'b0;
        @(negedge clk) chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.pos1", 32'(p1[0]), 640);
        check("rst.pos2", 32'(p2[0]), 960);
        check("rst.score", 32'(sc[0]), 0);
        check("rst.running", 32'(run[0]), 0);
        check("rst.b.pos1", 32'(p1[1]), 644);

        do_tick(5);
        check("idle.pos1", 32'(p1[0]), 640);
        check("idle.pos2", 32'(p2[0]), 960);

        press();
        check("start.running", 32'(run[0]), 1);
        do_tick(214);
        check("b.pos1_at2", 32'(p1[1]), 2);
        do_tick(1);
        check("b.clamp0", 32'(p1[1]), 0);
        do_tick(1);
        check("b.wrap637", 32'(p1[1]), 637);
        check("b.wrap1", 32'(w1[1]), 1);
        do_tick(4);
        check("t220.pos1", 32'(p1[0]), 200);
        check("t220.score", 32'(sc[0]), 0);
        do_tick(1);
        check("t221.pos1", 32'(p1[0]), 198);
        check("t221.score", 32'(sc[0]), 1);
        do_tick(99);
        check("t320.pos1", 32'(p1[0]), 0);
        check("t320.pos2", 32'(p2[0]), 320);
        do_tick(1);
        check("t321.pos1", 32'(p1[0]), 638);
        check("t321.wrap1", 32'(w1[0]), 1);
        check("t321.pos2", 32'(p2[0]), 318);
        do_tick(60);
        check("t381.score", 32'(sc[0]), 2);
        do_tick(9);
        check("t390.pos1", 32'(p1[0]), 500);

        @(negedge clk) btn = 1'b0;
        @(negedge clk) begin col = 1'b1; tick = 1'b1; end
        @(negedge clk) begin col = 1'b0; tick = 1'b0; end
        check("dead.pos1", 32'(p1[0]), 500);
        check("dead.pos2", 32'(p2[0]), 180);
        check("dead.score", 32'(sc[0]), 2);
        check("dead.running", 32'(run[0]), 0);
        do_tick(10);
        check("dead.hold.pos1", 32'(p1[0]), 500);
        check("dead.hold.score", 32'(sc[0]), 2);
        repeat (3) @(negedge clk);
        check("dead.btnheld", 32'(run[0]), 0);
        check("dead.btnheld.pos1", 32'(p1[0]), 500);

        @(negedge clk) btn = 1'b1;
        press();
        check("idle2.pos1", 32'(p1[0]), 640);
        check("idle2.pos2", 32'(p2[0]), 960);
        check("idle2.score", 32'(sc[0]), 2);
        press();
        check("restart.score", 32'(sc[0]), 0);
        check("restart.running", 32'(run[0]), 1);
        do_tick(5);
        check("restart.pos1", 32'(p1[0]), 630);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        check("midrst.pos1", 32'(p1[0]), 640);
        check("midrst.running", 32'(run[0]), 0);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            tick  = 1'($urandom_range(0, 1));
            btn   = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            col   = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
            rst_n = ($urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
